// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache with
// 16-byte lines; stalls the pipeline through BUSYWAIT while a miss is serviced.
module data_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         READ,
    input  logic         WRITE,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH, UPDATE} state_t;

    state_t state, state_next;
    logic [LINES-1:0] valid, dirty;
    logic [TAG_BITS-1:0] tags [LINES];
    logic [127:0] lines [LINES];

    logic [1:0] offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0] tag;
    logic request, hit, read_hit, write_hit, unused_bits;

    assign offset = ADDRESS[3:2];
    assign index = ADDRESS[4 +: INDEX_BITS];
    assign tag = ADDRESS[31 -: TAG_BITS];
    assign unused_bits = ^ADDRESS[1:0];
    assign request = READ || WRITE;
    assign hit = request && valid[index] && tags[index] == tag;
    assign read_hit = state == IDLE && READ && !WRITE && hit;
    assign write_hit = state == IDLE && WRITE && hit;
    assign READDATA = read_hit ? lines[index][{offset, 5'd0} +: 32] : '0;
    // Gated by RESET so the pipeline is released the moment reset asserts.
    assign BUSYWAIT = !RESET && (state != IDLE || (request && !hit));

    always_comb begin
        state_next = state;
        MEM_READ = 1'b0;
        MEM_WRITE = 1'b0;
        MEM_ADDRESS = '0;
        MEM_WRITEDATA = '0;
        case (state)
            IDLE: if (request && !hit) state_next = dirty[index] ? WRITE_BACK : FETCH;
            WRITE_BACK: begin
                MEM_WRITE = 1'b1;
                MEM_ADDRESS = {tags[index], index};
                MEM_WRITEDATA = lines[index];
                if (!MEM_BUSYWAIT) state_next = FETCH;
            end
            FETCH: begin
                MEM_READ = 1'b1;
                MEM_ADDRESS = ADDRESS[31:4];
                if (!MEM_BUSYWAIT) state_next = UPDATE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_next;
            if (state == UPDATE) begin
                valid[index] <= 1'b1;
                dirty[index] <= 1'b0;
            end else if (write_hit) begin
                dirty[index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset: valid bits qualify every use.
    always_ff @(posedge CLK) begin
        if (state == UPDATE) begin
            tags[index] <= tag;
            lines[index] <= MEM_READDATA;
        end else if (write_hit) begin
            lines[index][{offset, 5'd0} +: 32] <= WRITEDATA;
        end
    end
endmodule
